mc8123_fetch_ctrl: RTL

Sequences CPU program fetches through the MC8123 decryption path.
- Per read: latches the CPU address and M1, fetches the ROM byte, then performs the key-RAM lookup and the registered decrypt step.
- Holds the CPU in wait until the decrypted byte is ready.
- Shares the 8 KB key RAM port between the key download and decrypt lookups, and tracks key validity.
- Sits between the Z80 bus, the ROM/SDRAM arbiter and the external decrypt core.

---
 rtl/mc8123_pkg.sv | 20 ++
 rtl/mc8123_fetch_ctrl_if.sv | 24 ++
 rtl/mc8123_key_loader.sv | 52 +++++
 rtl/mc8123_fetch_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mc8123_pkg.sv
// mc8123 fetch path: shared types and constants.
// Used by the fetch controller and the key loader.
package mc8123_pkg;

  localparam int KEY_BYTES = 8192;
  localparam int KEY_AW    = 13;

  localparam logic [KEY_AW:0] KEY_FULL =
    KEY_BYTES[KEY_AW:0];

  localparam logic [15:0] DEC_LIMIT_DEF = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DEC,
    DONE
  } state_t;

endpackage

// File: rtl/mc8123_fetch_ctrl_if.sv
// mc8123 ROM request/acknowledge bus.
// master = fetch controller, slave = ROM arbiter.
interface mc8123_fetch_ctrl_if;

  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack;
  logic [7:0]  rom_data;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_ack,
    input  rom_data
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_ack,
    output rom_data
  );

endinterface

// File: rtl/mc8123_key_loader.sv
// mc8123 key download: byte counter, key RAM write
// port drive and key_valid tracking.
module mc8123_key_loader
  import mc8123_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [7:0]        dl_data,
  output logic              key_we,
  output logic [KEY_AW-1:0] key_waddr,
  output logic [7:0]        key_wdata,
  output logic              key_valid,
  output logic              dl_rise
);

  logic              r_dl_prev;
  logic [KEY_AW:0]   r_cnt;
  logic              r_key_valid;
  logic [KEY_AW:0]   w_cnt;
  logic              w_full;
  logic              w_dl_fall;

  assign dl_rise   = dl_active & ~r_dl_prev;
  assign w_dl_fall = ~dl_active & r_dl_prev;
  assign w_cnt     = dl_rise ? '0 : r_cnt;
  assign w_full    = (w_cnt == KEY_FULL);

  // bytes past a full key are dropped
  assign key_we    = dl_active & dl_wr & ~w_full;
  assign key_waddr = w_cnt[KEY_AW-1:0];
  assign key_wdata = dl_data;
  assign key_valid = r_key_valid;

  // counter and validity follow dl_active edges
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dl_prev   <= 1'b0;
      r_cnt       <= '0;
      r_key_valid <= 1'b0;
    end else begin
      r_dl_prev <= dl_active;
      r_cnt     <= w_cnt + {{KEY_AW{1'b0}}, key_we};
      if (dl_rise)
        r_key_valid <= 1'b0;
      else if (w_dl_fall)
        r_key_valid <= (r_cnt == KEY_FULL);
    end
  end

endmodule

// File: rtl/mc8123_fetch_ctrl.sv
// mc8123 fetch sequencer: ROM fetch, key lookup, decrypt.
// MC8123_OPCACHE_EN adds a one-entry decrypted-byte cache.
module mc8123_fetch_ctrl
  import mc8123_pkg::*;
#(
  parameter logic [15:0] DEC_LIMIT = DEC_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_m1,
  input  logic [15:0]       cpu_a,
  output logic              cpu_wait,
  output logic [7:0]        cpu_d,
  mc8123_fetch_ctrl_if.master rom,
  output logic [KEY_AW-1:0] key_addr,
  output logic              key_we,
  output logic [7:0]        key_wdata,
  input  logic [7:0]        key_rdata,
  output logic              dec_m1,
  output logic [15:0]       dec_a,
  input  logic [KEY_AW-1:0] dec_key_a,
  output logic [7:0]        dec_key_d,
  output logic [7:0]        dec_prog_d,
  input  logic [7:0]        dec_d,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [7:0]        dl_data,
  output logic              key_valid
);

  state_t            r_state;
  state_t            w_next;
  logic              r_rd_prev;
  logic [15:0]       r_a;
  logic              r_m1;
  logic              r_wait;
  logic [7:0]        r_d;
  logic              r_req;
  logic [7:0]        r_kd;
  logic [7:0]        r_pd;
  logic              r_first;
  logic              r_second;
  logic              r_byp;
  logic              w_rise;
  logic              w_ack;
  logic              w_byp;
  logic              w_hit;
  logic [7:0]        w_done_d;
  logic              w_key_valid;
  logic              w_dl_rise;
  logic              w_dl_we;
  logic [KEY_AW-1:0] w_dl_addr;

  mc8123_key_loader u_loader (
    .clk       (clk),
    .reset     (reset),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_data   (dl_data),
    .key_we    (w_dl_we),
    .key_waddr (w_dl_addr),
    .key_wdata (key_wdata),
    .key_valid (w_key_valid),
    .dl_rise   (w_dl_rise)
  );

  assign key_we    = w_dl_we;
  assign key_addr  = dl_active ? w_dl_addr : dec_key_a;
  assign key_valid = w_key_valid;

  assign cpu_wait     = r_wait;
  assign cpu_d        = r_d;
  assign rom.rom_req  = r_req;
  assign rom.rom_addr = r_a;
  assign dec_m1       = r_m1;
  assign dec_a        = r_a;
  assign dec_key_d    = r_kd;
  assign dec_prog_d   = r_pd;

  assign w_rise = cpu_rd & ~r_rd_prev;
  assign w_ack  = r_req & rom.rom_ack;
  assign w_byp  = (r_a >= DEC_LIMIT) | ~w_key_valid
                | dl_active;

`ifdef MC8123_OPCACHE_EN
  logic        r_c_valid;
  logic [16:0] r_c_tag;
  logic [7:0]  r_c_data;
  logic        r_hit;

  assign w_hit = r_c_valid
               & (r_c_tag == {cpu_m1, cpu_a});

  // fill on each decrypted result, drop on new key
  always_ff @(posedge clk) begin
    if (reset || w_dl_rise) begin
      r_c_valid <= 1'b0;
    end else if (r_state == DONE && !r_hit
                 && !(r_byp | w_byp)) begin
      r_c_valid <= 1'b1;
      r_c_tag   <= {r_m1, r_a};
      r_c_data  <= dec_d;
    end
  end

  // remember whether this fetch came from the cache
  always_ff @(posedge clk) begin
    if (reset)
      r_hit <= 1'b0;
    else if (r_state == IDLE && w_rise)
      r_hit <= w_hit;
  end
`else
  assign w_hit = 1'b0;
`endif

  // byte handed to the CPU when the fetch completes
  always_comb begin
    w_done_d = (r_byp | w_byp) ? r_pd : dec_d;
`ifdef MC8123_OPCACHE_EN
    if (r_hit)
      w_done_d = r_c_data;
`endif
  end

  // next state; an ack in the first FETCH cycle waits
  // one extra cycle so the key byte is captured first
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (w_rise)
          w_next = w_hit ? DONE : FETCH;
      FETCH:
        if (w_ack)
          w_next = w_byp ? DONE
                 : (r_first ? FETCH : DEC);
        else if (!r_req)
          w_next = w_byp ? DONE : DEC;
      DEC:
        w_next = DONE;
      DONE:
        w_next = IDLE;
      default:
        w_next = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // fetch datapath and CPU/ROM handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_prev <= 1'b0;
      r_a       <= '0;
      r_m1      <= 1'b0;
      r_wait    <= 1'b0;
      r_d       <= 8'hFF;
      r_req     <= 1'b0;
      r_kd      <= '0;
      r_pd      <= '0;
      r_first   <= 1'b0;
      r_second  <= 1'b0;
      r_byp     <= 1'b0;
    end else begin
      r_rd_prev <= cpu_rd;
      unique case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_a      <= cpu_a;
            r_m1     <= cpu_m1;
            r_wait   <= 1'b1;
            r_req    <= ~w_hit;
            r_first  <= 1'b1;
            r_second <= 1'b0;
            r_byp    <= 1'b0;
          end
        end
        FETCH: begin
          r_first  <= 1'b0;
          r_second <= r_first;
          if (r_second)
            r_kd <= key_rdata;
          if (w_ack) begin
            r_pd  <= rom.rom_data;
            r_req <= 1'b0;
            r_byp <= w_byp;
          end else if (!r_req) begin
            r_byp <= w_byp;
          end
        end
        DONE: begin
          r_wait <= 1'b0;
          r_d    <= w_done_d;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
